// File: rtl/wire_render_pipe.sv
// wire_render_pipe: renders up to NUM_EDGES thick line segments over a background colour, 3-stage pipelined
// Ports: pclk/rst_n clock and async active-low reset; h_cnt/v_cnt/vga_valid/frame_start from the VGA timing;
// edge_wr_*/col_wr_* write the shadow edge table and palette; commit arms a shadow-to-active copy at the next
// frame_start; vga_data is the registered pixel colour; pending shows a commit still waiting for frame_start.
module wire_render_pipe #(
    parameter int          NUM_EDGES = 6,
    parameter int          THICK     = 1,
    parameter logic [11:0] BG_COLOR  = 12'h49C
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        vga_valid,
    input  logic        frame_start,
    input  logic        edge_wr_en,
    input  logic [3:0]  edge_wr_idx,
    input  logic [9:0]  edge_wr_x0,
    input  logic [9:0]  edge_wr_y0,
    input  logic [9:0]  edge_wr_x1,
    input  logic [9:0]  edge_wr_y1,
    input  logic        edge_wr_on,
    input  logic        col_wr_en,
    input  logic [3:0]  col_wr_idx,
    input  logic [11:0] col_wr_data,
    input  logic        commit,
    output logic [11:0] vga_data,
    output logic        pending
);
    typedef struct packed {
        logic [9:0]  x0, y0, x1, y1;
        logic        on;
        logic [11:0] col;
    } ent_t;
    localparam logic [71:0] DEF_COL = {12'h0FF, 12'hF0F, 12'hFF0, 12'h00F, 12'h0F0, 12'hF00};
    ent_t sh [NUM_EDGES];
    ent_t act [NUM_EDGES];
    logic signed [21:0] pa [NUM_EDGES], pb [NUM_EDGES], pa_q [NUM_EDGES], pb_q [NUM_EDGES];
    logic [11:0] thr [NUM_EDGES], thr_q [NUM_EDGES], col1 [NUM_EDGES], col2 [NUM_EDGES];
    logic box [NUM_EDGES], box_q [NUM_EDGES], hit_d [NUM_EDGES], hit_q [NUM_EDGES];
    logic v1, v2;
    logic [11:0] pix_col;
    // Copy reads sh before this edge's writes land, so a same-cycle write stays in shadow only
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            for (int i = 0; i < NUM_EDGES; i++) begin
                sh[i]  <= {41'b0, DEF_COL[12*(i%6) +: 12]};
                act[i] <= {41'b0, DEF_COL[12*(i%6) +: 12]};
            end
        end else begin
            if (frame_start && (pending || commit))
                act <= sh;
            pending <= !frame_start && (pending || commit);
            for (int i = 0; i < NUM_EDGES; i++) begin
                if (edge_wr_en && edge_wr_idx == 4'(i))
                    {sh[i].x0, sh[i].y0, sh[i].x1, sh[i].y1, sh[i].on} <=
                        {edge_wr_x0, edge_wr_y0, edge_wr_x1, edge_wr_y1, edge_wr_on};
                if (col_wr_en && col_wr_idx == 4'(i))
                    sh[i].col <= col_wr_data;
            end
        end
    end
    for (genvar e = 0; e < NUM_EDGES; e++) begin : g_edge
        logic signed [10:0] dx, dy, rh, rv;
        logic [10:0] adx, ady;
        logic signed [11:0] hs, vs, xlo, xhi, ylo, yhi;
        logic signed [22:0] df;
        logic [22:0] adf;
        assign dx  = $signed({1'b0, act[e].x1}) - $signed({1'b0, act[e].x0});
        assign dy  = $signed({1'b0, act[e].y1}) - $signed({1'b0, act[e].y0});
        assign rh  = $signed({1'b0, h_cnt}) - $signed({1'b0, act[e].x0});
        assign rv  = $signed({1'b0, v_cnt}) - $signed({1'b0, act[e].y0});
        assign adx = dx[10] ? -dx : dx;
        assign ady = dy[10] ? -dy : dy;
        assign hs  = $signed({2'b0, h_cnt});
        assign vs  = $signed({2'b0, v_cnt});
        // 12-bit signed limits keep a box touching row/column 0 from wrapping to the far edge
        assign xlo = $signed({2'b0, dx[10] ? act[e].x1 : act[e].x0}) - 12'(THICK);
        assign xhi = $signed({2'b0, dx[10] ? act[e].x0 : act[e].x1}) + 12'(THICK);
        assign ylo = $signed({2'b0, dy[10] ? act[e].y1 : act[e].y0}) - 12'(THICK);
        assign yhi = $signed({2'b0, dy[10] ? act[e].y0 : act[e].y1}) + 12'(THICK);
        assign box[e] = act[e].on && hs >= xlo && hs <= xhi && vs >= ylo && vs <= yhi;
        assign pa[e]  = 22'(dx) * 22'(rv);
        assign pb[e]  = 22'(dy) * 22'(rh);
        assign thr[e] = 12'(THICK) * {1'b0, adx > ady ? adx : ady};
        assign df     = $signed({pa_q[e][21], pa_q[e]}) - $signed({pb_q[e][21], pb_q[e]});
        assign adf    = df[22] ? -df : df;
        assign hit_d[e] = box_q[e] && adf <= {11'b0, thr_q[e]};
    end
    // Lowest index is applied last so it wins
    always_comb begin
        pix_col = BG_COLOR;
        for (int i = NUM_EDGES - 1; i >= 0; i--)
            pix_col = hit_q[i] ? col2[i] : pix_col;
    end
    // Colours travel with the pixel so a table copy never affects pixels already in flight
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            vga_data <= 12'h000;
            for (int i = 0; i < NUM_EDGES; i++) begin
                pa_q[i]  <= '0;
                pb_q[i]  <= '0;
                thr_q[i] <= '0;
                box_q[i] <= 1'b0;
                col1[i]  <= '0;
                hit_q[i] <= 1'b0;
                col2[i]  <= '0;
            end
        end else begin
            v1       <= vga_valid;
            v2       <= v1;
            vga_data <= v2 ? pix_col : 12'h000;
            for (int i = 0; i < NUM_EDGES; i++) begin
                pa_q[i]  <= pa[i];
                pb_q[i]  <= pb[i];
                thr_q[i] <= thr[i];
                box_q[i] <= box[i];
                col1[i]  <= act[i].col;
                hit_q[i] <= hit_d[i];
                col2[i]  <= col1[i];
            end
        end
    end
endmodule

// File: tb/tb_wire_render_pipe.sv
// tb_wire_render_pipe: directed vectors with a scoreboard queue checked by an independent monitor
module tb_wire_render_pipe;
    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  h_cnt, v_cnt;
    logic        vga_valid, frame_start, edge_wr_en, edge_wr_on, col_wr_en, commit;
    logic [3:0]  edge_wr_idx, col_wr_idx;
    logic [9:0]  edge_wr_x0, edge_wr_y0, edge_wr_x1, edge_wr_y1;
    logic [11:0] col_wr_data;
    logic [11:0] vga_data;
    logic        pending;
    typedef struct {
        int          id;
        int          due;
        logic [11:0] exp;
    } sb_t;
    sb_t q[$];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int pid = 0;
    wire_render_pipe dut (
        .pclk(pclk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .vga_valid(vga_valid),
        .frame_start(frame_start), .edge_wr_en(edge_wr_en), .edge_wr_idx(edge_wr_idx),
        .edge_wr_x0(edge_wr_x0), .edge_wr_y0(edge_wr_y0), .edge_wr_x1(edge_wr_x1),
        .edge_wr_y1(edge_wr_y1), .edge_wr_on(edge_wr_on), .col_wr_en(col_wr_en),
        .col_wr_idx(col_wr_idx), .col_wr_data(col_wr_data), .commit(commit),
        .vga_data(vga_data), .pending(pending)
    );
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;
    initial begin
        sb_t s;
        forever begin
            @(negedge pclk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                s = q.pop_front();
                n_chk++;
                if (vga_data !== s.exp) begin
                    n_fail++;
                    $display("FAIL pix%0d vga_data got %h expected %h", s.id, vga_data, s.exp);
                end
            end
        end
    end
    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask
    task automatic clr();
        vga_valid = 1'b0; frame_start = 1'b0; commit = 1'b0; edge_wr_en = 1'b0; col_wr_en = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            clr();
        end
    endtask
    task automatic wr_edge(input int idx, input int x0, input int y0, input int x1, input int y1, input int on);
        @(negedge pclk);
        clr();
        edge_wr_en = 1'b1; edge_wr_idx = 4'(idx); edge_wr_on = 1'(on);
        edge_wr_x0 = 10'(x0); edge_wr_y0 = 10'(y0); edge_wr_x1 = 10'(x1); edge_wr_y1 = 10'(y1);
    endtask
    task automatic col_wr(input int idx, input logic [11:0] d, input logic fs);
        @(negedge pclk);
        clr();
        col_wr_en = 1'b1; col_wr_idx = 4'(idx); col_wr_data = d; frame_start = fs;
    endtask
    task automatic ctl(input logic fs, input logic cm);
        @(negedge pclk);
        clr();
        frame_start = fs; commit = cm;
    endtask
    task automatic pix(input int h, input int v, input logic val, input logic [11:0] exp);
        @(negedge pclk);
        clr();
        h_cnt = 10'(h); v_cnt = 10'(v); vga_valid = val;
        q.push_back('{pid, cyc + 3, exp});
        pid++;
    endtask
    initial begin
        clr();
        h_cnt = '0; v_cnt = '0; edge_wr_idx = '0; edge_wr_on = 1'b0; col_wr_idx = '0; col_wr_data = '0;
        edge_wr_x0 = '0; edge_wr_y0 = '0; edge_wr_x1 = '0; edge_wr_y1 = '0;
        #3;
        chk("reset_data", vga_data, 12'h000);
        chk("reset_pending", {11'b0, pending}, 12'h000);
        @(negedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        pix(10, 10, 1, 12'h49C);
        pix(639, 479, 1, 12'h49C);
        pix(5, 5, 0, 12'h000);
        wr_edge(0, 100, 100, 200, 100, 1);
        ctl(0, 1);
        idle(1);
        chk("commit_sets_pending", {11'b0, pending}, 12'h001);
        pix(150, 100, 1, 12'h49C);
        ctl(1, 0);
        idle(1);
        chk("frame_start_clears_pending", {11'b0, pending}, 12'h000);
        pix(150, 100, 1, 12'hF00);
        pix(150, 101, 1, 12'hF00);
        pix(150, 102, 1, 12'h49C);
        pix(99, 100, 1, 12'hF00);
        pix(202, 100, 1, 12'h49C);
        pix(150, 100, 0, 12'h000);
        wr_edge(0, 50, 40, 50, 60, 1);
        wr_edge(2, 40, 50, 60, 50, 1);
        ctl(1, 1);
        idle(1);
        chk("same_cycle_commit_pending", {11'b0, pending}, 12'h000);
        pix(50, 50, 1, 12'hF00);
        pix(150, 100, 1, 12'h49C);
        wr_edge(0, 50, 40, 50, 60, 0);
        ctl(0, 1);
        pix(50, 50, 1, 12'hF00);
        ctl(1, 0);
        pix(50, 50, 1, 12'h00F);
        col_wr(2, 12'h123, 1'b0);
        ctl(0, 1);
        col_wr(2, 12'h456, 1'b1);
        idle(1);
        chk("write_with_copy_pending", {11'b0, pending}, 12'h000);
        pix(50, 50, 1, 12'h123);
        ctl(0, 1);
        ctl(1, 0);
        pix(50, 50, 1, 12'h456);
        wr_edge(1, 0, 0, 0, 479, 1);
        wr_edge(3, 320, 240, 320, 240, 1);
        wr_edge(4, 10, 10, 20, 20, 1);
        ctl(1, 1);
        pix(0, 0, 1, 12'h0F0);
        pix(639, 0, 1, 12'h49C);
        pix(1, 0, 1, 12'h0F0);
        pix(2, 0, 1, 12'h49C);
        pix(0, 479, 1, 12'h0F0);
        pix(319, 239, 1, 12'hFF0);
        pix(321, 241, 1, 12'hFF0);
        pix(322, 240, 1, 12'h49C);
        pix(320, 238, 1, 12'h49C);
        pix(15, 15, 1, 12'hF0F);
        pix(15, 16, 1, 12'hF0F);
        pix(15, 17, 1, 12'h49C);
        ctl(0, 1);
        pix(15, 15, 1, 12'hF0F);
        pix(15, 15, 1, 12'hF0F);
        pix(15, 15, 1, 12'hF0F);
        @(posedge pclk);
        #2;
        chk("before_reset_data", vga_data, 12'hF0F);
        rst_n = 1'b0;
        #1;
        chk("async_reset_data", vga_data, 12'h000);
        chk("async_reset_pending", {11'b0, pending}, 12'h000);
        q.delete();
        @(negedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        idle(1);
        chk("after_release_data", vga_data, 12'h000);
        pix(15, 15, 1, 12'h49C);
        pix(0, 0, 1, 12'h49C);
        pix(50, 50, 1, 12'h49C);
        for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain outstanding %0d expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
